// File: rtl/svm_pkg.sv
// -----------------------------------------------------------------------------
// svm_pkg
//   Definitions shared by the SVM memory controller, the pixel buffer and the
//   decision-function kernel evaluator.
//
//   Contents:
//     SVM_XLEN_PIXEL     default pixel width in bits
//     SVM_NUM_OF_PIXELS  default pixels per test-vector frame
//     SVM_ADDR_W         default pixel address width (2**W >= pixels)
//     pixel_t            one pixel at the default width
//     buf_state_t        pixel buffer state encoding (LOAD / FULL / STREAM)
// -----------------------------------------------------------------------------
package svm_pkg;

  localparam int SVM_XLEN_PIXEL    = 8;
  localparam int SVM_NUM_OF_PIXELS = 784;
  localparam int SVM_ADDR_W        = 10;

  typedef logic [SVM_XLEN_PIXEL-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,  // accepting pixels from the source
    ST_FULL   = 2'd1,  // frame captured, waiting for the read phase
    ST_STREAM = 2'd2   // streaming the frame to the decision function
  } buf_state_t;

endpackage : svm_pkg

// File: rtl/svm_pixel_ram.sv
// -----------------------------------------------------------------------------
// svm_pixel_ram
//   Simple dual-port, single-clock pixel RAM. One write port, one read port
//   with a registered output (one cycle of read latency). The output register
//   holds its value while rd_en_i is low, so it doubles as the data half of the
//   streaming beat register in svm_pixel_buffer. Written to be inferred as a
//   block RAM with an output register that has a synchronous reset.
//
//   Ports:
//     clk        system clock
//     rst        synchronous active-high reset (output register only)
//     wr_en_i    write strobe
//     wr_addr_i  write address
//     wr_data_i  write data
//     rd_en_i    read enable; loads rd_data_o from mem[rd_addr_i]
//     rd_addr_i  read address
//     rd_data_o  registered read data
// -----------------------------------------------------------------------------
module svm_pixel_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the storage array is deliberately left without a reset; resetting it
  // would turn the block RAM into a huge bank of flops.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      // NOTE: sequential state is updated with <= so every flop samples the
      // values that existed before the clock edge.
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : svm_pixel_ram

// File: rtl/svm_pixel_buffer.sv
// -----------------------------------------------------------------------------
// svm_pixel_buffer
//   Storage-side responder to the SVM memory controller. During the write
//   phase it captures one frame of NUM_OF_PIXELS pixels; during the read phase
//   it streams the frame to the decision-function datapath over valid/ready.
//
//   State flow: LOAD --(last write)--> FULL --(re & !stall)--> STREAM
//               STREAM --(handshake on last beat)--> LOAD
//
//   Ports:
//     clk         system clock
//     rst         synchronous active-high reset
//     we          write strobe, one pixel per cycle while high
//     re          read-phase enable (only acted on in FULL)
//     stall_MEM   controller stall; freezes the read side
//     wr_data     pixel to store
//     rd_ready    decision-function ready
//     rd_valid    rd_data valid (beat valid and not stalled)
//     rd_data     pixel out
//     rd_addr     index of the pixel on rd_data
//     rd_last     high with the final pixel of the frame
//     load_done   level: frame fully captured
//     frame_done  one-cycle pulse after the last read handshake
//     overflow    sticky until rst: a write was dropped
//     checksum    (PIXEL_CHECKSUM_EN only) sum of pixels accepted this frame
//
//   Build option: define PIXEL_CHECKSUM_EN to add the checksum output.
// -----------------------------------------------------------------------------
module svm_pixel_buffer
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL    = SVM_XLEN_PIXEL,
  parameter int NUM_OF_PIXELS = SVM_NUM_OF_PIXELS,
  parameter int ADDR_W        = SVM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic                  stall_MEM,
  input  logic [XLEN_PIXEL-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [XLEN_PIXEL-1:0] rd_data,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_last,
  output logic                  load_done,
  output logic                  frame_done,
  output logic                  overflow
`ifdef PIXEL_CHECKSUM_EN
  ,
  output logic [XLEN_PIXEL+ADDR_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_OF_PIXELS - 1);

  buf_state_t        state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;      // next address to fetch
  logic              beat_valid_q;  // beat register holds a pixel not yet taken
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_last_q;
  logic              load_done_q;
  logic              frame_done_q;
  logic              overflow_q;

  logic handshake;
  logic fetch;
  logic last_hs;
  logic ram_we;

  assign rd_valid  = beat_valid_q & ~stall_MEM;
  assign handshake = rd_valid & rd_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    fetch   = 1'b0;
    last_hs = 1'b0;
    ram_we  = 1'b0;
    if (state_q == ST_LOAD) begin
      ram_we = we;
    end
    if (state_q == ST_STREAM) begin
      // Fetch to fill an empty beat register, or to replace a beat that is
      // being consumed, as long as that beat is not the final one. A stall
      // blocks the fetch, so the pending beat survives the stall unchanged.
      fetch   = ~stall_MEM & (~beat_valid_q | (handshake & ~rd_last_q));
      last_hs = handshake & rd_last_q;
    end
  end

  svm_pixel_ram #(
    .DATA_W (XLEN_PIXEL),
    .DEPTH  (NUM_OF_PIXELS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (fetch),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      beat_valid_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_last_q    <= 1'b0;
      load_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          if (we) begin
            // The pointer parks on the last address instead of wrapping.
            if (wr_ptr_q == LAST_ADDR) begin
              state_q     <= ST_FULL;
              load_done_q <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
          end
        end

        ST_FULL: begin
          if (we) begin
            overflow_q <= 1'b1;
          end
          if (re && !stall_MEM) begin
            state_q  <= ST_STREAM;
            rd_ptr_q <= '0;
          end
        end

        ST_STREAM: begin
          if (we) begin
            overflow_q <= 1'b1;
          end
          if (fetch) begin
            beat_valid_q <= 1'b1;
            rd_addr_q    <= rd_ptr_q;
            rd_last_q    <= (rd_ptr_q == LAST_ADDR);
            if (rd_ptr_q != LAST_ADDR) begin
              rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
          end
          if (last_hs) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            load_done_q  <= 1'b0;
            beat_valid_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_last_q    <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end

        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign rd_addr    = rd_addr_q;
  assign rd_last    = rd_last_q;
  assign load_done  = load_done_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

`ifdef PIXEL_CHECKSUM_EN
  localparam int CSUM_W = XLEN_PIXEL + ADDR_W;

  logic [CSUM_W-1:0] checksum_q;

  // Width XLEN_PIXEL+ADDR_W cannot overflow for a full frame of max pixels.
  always_ff @(posedge clk) begin
    if (rst || last_hs) begin
      checksum_q <= '0;
    end else if (ram_we) begin
      checksum_q <= checksum_q + CSUM_W'(wr_data);
    end
  end

  assign checksum = checksum_q;
`endif

endmodule : svm_pixel_buffer

// File: tb/tb_svm_pixel_buffer.sv
// -----------------------------------------------------------------------------
// tb_svm_pixel_buffer
//   Directed bench for svm_pixel_buffer with an 8-pixel frame. Inputs change
//   1 time unit after the rising edge; outputs are compared at the same point,
//   i.e. reflecting the state left by the preceding edge.
// -----------------------------------------------------------------------------
module tb_svm_pixel_buffer;

  localparam int XLEN = 8;
  localparam int NPIX = 8;
  localparam int AW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic            re;
  logic            stall_MEM;
  logic [XLEN-1:0] wr_data;
  logic            rd_ready;
  logic            rd_valid;
  logic [XLEN-1:0] rd_data;
  logic [AW-1:0]   rd_addr;
  logic            rd_last;
  logic            load_done;
  logic            frame_done;
  logic            overflow;
`ifdef PIXEL_CHECKSUM_EN
  logic [XLEN+AW-1:0] checksum;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  svm_pixel_buffer #(
    .XLEN_PIXEL    (XLEN),
    .NUM_OF_PIXELS (NPIX),
    .ADDR_W        (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .re         (re),
    .stall_MEM  (stall_MEM),
    .wr_data    (wr_data),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_addr    (rd_addr),
    .rd_last    (rd_last),
    .load_done  (load_done),
    .frame_done (frame_done),
    .overflow   (overflow)
`ifdef PIXEL_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Writes base..base+7; load_done must rise only after the 8th write.
  task automatic load_frame(input int base);
    for (int i = 0; i < NPIX; i++) begin
      we      = 1'b1;
      wr_data = XLEN'(base + i);
      tick();
      check("load_done_during_load", {31'd0, load_done}, {31'd0, (i == NPIX - 1)});
    end
    we = 1'b0;
  endtask

  // Full-speed stream from FULL; expects base..base+7 on consecutive cycles.
  task automatic stream_frame(input int base);
    re       = 1'b1;
    rd_ready = 1'b1;
    tick();
    check("stream_first_cycle_valid", {31'd0, rd_valid}, 32'd0);
    re = 1'b0;
    tick();
    for (int k = 0; k < NPIX; k++) begin
      check("stream_valid", {31'd0, rd_valid}, 32'd1);
      check("stream_data", {24'd0, rd_data}, 32'(base + k));
      check("stream_addr", {29'd0, rd_addr}, 32'(k));
      check("stream_last", {31'd0, rd_last}, {31'd0, (k == NPIX - 1)});
      tick();
    end
    check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    check("load_done_cleared", {31'd0, load_done}, 32'd0);
    check("valid_after_frame", {31'd0, rd_valid}, 32'd0);
    rd_ready = 1'b0;
    tick();
    check("frame_done_single", {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    int idx;
    logic [9:0] ready_pat;

    rst       = 1'b1;
    we        = 1'b0;
    re        = 1'b0;
    stall_MEM = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_rd_addr", {29'd0, rd_addr}, 32'd0);
    check("rst_rd_last", {31'd0, rd_last}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // 1. Basic frame 10..17
`ifdef PIXEL_CHECKSUM_EN
    check("checksum_initial", 32'(checksum), 32'd0);
`endif
    load_frame(10);
`ifdef PIXEL_CHECKSUM_EN
    check("checksum_full", 32'(checksum), 32'd108);
`endif
    stream_frame(10);
`ifdef PIXEL_CHECKSUM_EN
    check("checksum_cleared", 32'(checksum), 32'd0);
`endif

    // 2. Backpressure: ready 1,0,0,1,... over 20..27
    load_frame(20);
    re       = 1'b1;
    rd_ready = 1'b1;
    tick();
    re = 1'b0;
    tick();
    ready_pat = 10'b1111111001;  // bit c applies to cycle c
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      rd_ready = ready_pat[c];
      check("bp_valid", {31'd0, rd_valid}, 32'd1);
      check("bp_addr", {29'd0, rd_addr}, 32'(idx));
      check("bp_data", {24'd0, rd_data}, 32'(20 + idx));
      tick();
      if (ready_pat[c]) idx++;
    end
    check("bp_handshakes", 32'(idx), 32'd8);
    check("bp_frame_done", {31'd0, frame_done}, 32'd1);
    rd_ready = 1'b0;
    tick();

    // 3. Stall for 3 cycles while addr 3 is presented
    load_frame(10);
    re       = 1'b1;
    rd_ready = 1'b1;
    tick();
    re = 1'b0;
    tick();
    for (int c = 0; c < NPIX; c++) begin
      if (c == 3) begin
        stall_MEM = 1'b1;
        #1;
        check("stall_masks_valid", {31'd0, rd_valid}, 32'd0);
        repeat (3) begin
          tick();
          check("stall_valid_low", {31'd0, rd_valid}, 32'd0);
          check("stall_addr_held", {29'd0, rd_addr}, 32'd3);
        end
        stall_MEM = 1'b0;
        #1;
      end
      check("stall_seq_valid", {31'd0, rd_valid}, 32'd1);
      check("stall_seq_addr", {29'd0, rd_addr}, 32'(c));
      check("stall_seq_data", {24'd0, rd_data}, 32'(10 + c));
      tick();
    end
    check("stall_frame_done", {31'd0, frame_done}, 32'd1);
    rd_ready = 1'b0;
    tick();

    // 4. Early re during LOAD, then a 9th write
    re = 1'b1;
    tick();
    tick();
    check("early_re_no_stream", {31'd0, rd_valid}, 32'd0);
    check("early_re_no_load_done", {31'd0, load_done}, 32'd0);
    load_frame(30);
    check("early_re_still_idle", {31'd0, rd_valid}, 32'd0);
    re      = 1'b0;
    we      = 1'b1;
    wr_data = 8'd99;
    tick();
    we = 1'b0;
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check("overflow_load_done", {31'd0, load_done}, 32'd1);
    tick();
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    stream_frame(30);
    check("overflow_sticky_after_frame", {31'd0, overflow}, 32'd1);

    // 5. Reset while addr 4 is presented
    load_frame(40);
    re       = 1'b1;
    rd_ready = 1'b1;
    tick();
    re = 1'b0;
    tick();
    repeat (4) tick();
    check("pre_rst_addr", {29'd0, rd_addr}, 32'd4);
    check("pre_rst_data", {24'd0, rd_data}, 32'd44);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    rd_ready = 1'b0;
    check("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("mid_rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("mid_rst_rd_addr", {29'd0, rd_addr}, 32'd0);
    check("mid_rst_rd_last", {31'd0, rd_last}, 32'd0);
    check("mid_rst_load_done", {31'd0, load_done}, 32'd0);
    check("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    load_frame(50);
    stream_frame(50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_svm_pixel_buffer

// File: doc/svm_pixel_buffer.md
Name:
svm_pixel_buffer

Overview:
- Storage-side responder to the SVM memory controller's write/read phase signals (we, re, stall_MEM).
- Write phase: captures one test-vector frame of pixels into an internal buffer.
- Read phase: streams the frame out to the decision-function datapath over a valid/ready handshake.
- Sits between the pixel source/controller and the decision-function kernel evaluator.

Parameters:
- XLEN_PIXEL, 8, pixel width in bits.
- NUM_OF_PIXELS, 784, pixels per frame (buffer depth).
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= NUM_OF_PIXELS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- we  in  1  write strobe from controller; one pixel per cycle while high.
- re  in  1  read-phase enable from controller.
- stall_MEM  in  1  controller stall; freezes the read side.
- wr_data  in  XLEN_PIXEL  pixel to store.
- rd_ready  in  1  decision-function ready.
- rd_valid  out  1  rd_data valid.
- rd_data  out  XLEN_PIXEL  pixel out.
- rd_addr  out  ADDR_W  index of the pixel on rd_data.
- rd_last  out  1  high with the final pixel of the frame.
- load_done  out  1  frame fully captured; level signal.
- frame_done  out  1  one-cycle pulse after the last read handshake.
- overflow  out  1  sticky; a write was dropped.

Behaviour:
- One clock domain; reset is synchronous and active-high, ports named clk and rst.
- Reset values:
  - State = LOAD, wr_ptr = 0, rd_ptr = 0.
  - rd_valid, rd_last, load_done, frame_done, overflow = 0; rd_data, rd_addr = 0.
  - Memory contents are not cleared.
- rst mid-operation aborts any load or stream; the next cycle is clean LOAD.
- States: LOAD, FULL, STREAM.
- LOAD:
  - we=1 writes wr_data to mem[wr_ptr], then wr_ptr++.
  - The write at wr_ptr = NUM_OF_PIXELS-1 moves the block to FULL; load_done=1 from the next cycle.
  - re is ignored in LOAD; we wins if both are high.
- FULL:
  - we=1 drops the pixel and sets overflow (sticky until rst).
  - re=1 with stall_MEM=0 moves the block to STREAM with rd_ptr = 0.
- STREAM:
  - Synchronous memory read with 1-cycle latency: entering STREAM at cycle T gives rd_valid at T+1 (if not stalled).
  - Internal beat register holds rd_data, rd_addr and rd_last.
  - rd_valid = beat_valid AND NOT stall_MEM.
  - A handshake is rd_valid AND rd_ready. On a handshake, the next address is fetched so back-to-back beats issue every cycle.
  - Without a handshake, rd_data, rd_addr and rd_last hold stable.
  - stall_MEM=1 masks rd_valid, pauses rd_ptr and keeps the pending beat. The beat is re-presented unchanged when the stall drops.
  - rd_last = 1 exactly when rd_addr = NUM_OF_PIXELS-1.
  - Handshake on the last beat:
    - Next state LOAD; wr_ptr, rd_ptr, load_done and beat_valid clear.
    - frame_done = 1 for that single next cycle.
    - A we in that cycle is accepted at address 0.
  - we during STREAM is dropped and sets overflow.
  - re deassertion during STREAM is ignored; the frame completes.
- Pointer wrap: pointers never exceed NUM_OF_PIXELS-1; there is no modulo wrap.

Optional Feature:
- Macro PIXEL_CHECKSUM_EN.
- Defined:
  - Adds output checksum [XLEN_PIXEL+ADDR_W-1:0], the unsigned sum of all pixels accepted in the current frame.
  - Cleared on rst and at each LOAD re-entry.
  - Valid whenever load_done=1.
- Undefined: no port, no adder; all other behaviour identical.

Decomposition:
- Shared package svm_pkg:
  - Pixel type of XLEN_PIXEL bits.
  - Buffer state encoding (LOAD/FULL/STREAM).
  - Default NUM_OF_PIXELS and XLEN_PIXEL constants, shared with the controller and the decision function.
- One sub-module, svm_pixel_ram: simple dual-port, single-clock RAM with a registered read port, inferable as BRAM.
- FSM, pointers and handshake logic live in svm_pixel_buffer.

Test Plan:
All scenarios use NUM_OF_PIXELS = 8.
1. Basic frame:
   - Stimulus: we high for 8 cycles with data 10..17, then re=1 with rd_ready=1.
   - Response: load_done=1 the cycle after the 8th write; rd_data 10..17 on consecutive cycles, rd_addr 0..7, rd_last only at 7; frame_done pulses once; state returns to LOAD.
2. Backpressure:
   - Stimulus: rd_ready toggled 1,0,0,1 during the stream.
   - Response: rd_data/rd_addr hold while rd_ready=0; no pixel skipped or duplicated; 8 handshakes total.
3. Stall:
   - Stimulus: stall_MEM=1 for 3 cycles while presenting addr 3.
   - Response: rd_valid=0 during the stall; addr 3 with value 13 re-presented afterwards; sequence completes.
4. Overflow and early re:
   - Stimulus: re=1 during LOAD, then a 9th we.
   - Response: no stream starts before FULL; overflow=1 and stays 1; buffer contents unchanged.
5. Reset mid-stream:
   - Stimulus: rst for 1 cycle at addr 4.
   - Response: all outputs at reset values; a new 8-pixel load and stream works normally.
6. PIXEL_CHECKSUM_EN defined:
   - Stimulus: load pixels 10..17.
   - Response: checksum = 108; cleared after frame_done.
